// File: rtl/ticker_pkg.sv
// Shared constants and types for the ticker scroller.
// The optional TICKER_PAUSE_EN build only adds a top-level input, so nothing here depends on it.
package ticker_pkg;
  localparam int CODE_W = 4;
  localparam int DIGITS = 8;
  localparam logic [DIGITS-1:0] ENABLE_RST = 8'b1111_1110;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } buf_state_t;
endpackage

// File: rtl/ticker_tick_gen.sv
// Free-running divider.
// It raises a one-cycle tick on the last count of every DIV-cycle period.
module ticker_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ticker_scroller.sv
// Double-buffered scrolling message feeder for an 8-digit multiplexed 7-segment display.
// Define TICKER_PAUSE_EN to add a pause input that freezes scrolling.
module ticker_scroller
  import ticker_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int SCROLL_DIV  = 25_000_000,
  parameter int REFRESH_DIV = 100_000,
  localparam int AW         = $clog2(MSG_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  input  logic              commit,
  output logic              wr_ready,
  output logic [CODE_W-1:0] digit_code,
  output logic [DIGITS-1:0] enable,
  output logic [AW-1:0]     scroll_pos
`ifdef TICKER_PAUSE_EN
  ,
  input  logic              pause
`endif
);
  localparam int IW = $clog2(DIGITS);

  logic scroll_tick, refresh_tick, pause_on;

  buf_state_t state_q, state_d;
  logic [AW-1:0]     offset_q, offset_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] enable_q, enable_d;
  logic [CODE_W-1:0] digit_code_q, digit_code_d;
  logic [CODE_W-1:0] shadow_q [MSG_LEN];
  logic [CODE_W-1:0] shadow_d [MSG_LEN];
  logic [CODE_W-1:0] active_q [MSG_LEN];
  logic [CODE_W-1:0] active_d [MSG_LEN];

`ifdef TICKER_PAUSE_EN
  assign pause_on = pause;
`else
  assign pause_on = 1'b0;
`endif

  ticker_tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .clk (clk),
    .rst (rst),
    .tick(scroll_tick)
  );

  ticker_tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
    .clk (clk),
    .rst (rst),
    .tick(refresh_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit)      state_d = PENDING;
      PENDING: if (scroll_tick) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state_q == IDLE);
  end

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    offset_d     = offset_q;
    idx_d        = idx_q;
    enable_d     = enable_q;
    digit_code_d = digit_code_q;

    if (wr_ready && wr_en) shadow_d[wr_addr] = wr_data;

    // A completing commit rewinds the window instead of stepping it, even while paused.
    if (state_q == PENDING && scroll_tick) begin
      active_d = shadow_q;
      offset_d = '0;
    end else if (scroll_tick && !pause_on) begin
      offset_d = up ? offset_q + AW'(1) : offset_q - AW'(1);
    end

    // The refresh reads the pre-update window, so a simultaneous step shows on the next slot.
    if (refresh_tick) begin
      idx_d        = idx_q + IW'(1);
      enable_d     = ~(DIGITS'(1) << idx_d);
      digit_code_d = active_q[offset_q + AW'(idx_d)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      offset_q     <= '0;
      idx_q        <= '0;
      enable_q     <= ENABLE_RST;
      digit_code_q <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      offset_q     <= offset_d;
      idx_q        <= idx_d;
      enable_q     <= enable_d;
      digit_code_q <= digit_code_d;
    end
  end

  assign enable     = enable_q;
  assign digit_code = digit_code_q;
  assign scroll_pos = offset_q;
endmodule
